mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle controller for the EX-stage multiply (ALU operation code 4'b1110). When a valid MUL sits in EX, the block freezes the pipeline with a stall signal. It runs an iterative shift-add multiply, then releases the pipeline for exactly one cycle with the low DATA_WIDTH bits of the product presented for the EX/MEM register. It sits beside the ALU, driven by the ALU control output and the forwarded operands, with stall_o feeding the hazard/stall logic.

## Interface
- DATA_WIDTH, 32, operand/result width (≥2)
- MUL_OP, 4'b1110, ALU operation code that triggers the sequencer
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ALU_Operation_i  in  4  operation code from ALU control for the instruction in EX
- valid_i  in  1  EX holds a real instruction (0 = bubble)
- flush_i  in  1  EX instruction is being squashed (branch/jump taken)
- multiplicand_i  in  DATA_WIDTH  rs1 operand (post-forwarding)
- multiplier_i  in  DATA_WIDTH  rs2 operand (post-forwarding)
- stall_o  out  1  hold PC, IF/ID, ID/EX; bubble into EX/MEM
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  DATA_WIDTH  product, low DATA_WIDTH bits

## Operation
- Internal: state {IDLE, RUN, DONE}; A (shifted multiplicand), B (shifted multiplier), P (accumulator), cnt (iteration count, clog2(DATA_WIDTH)+1 bits).
- start = (state==IDLE) & valid_i & (ALU_Operation_i==MUL_OP) & ~flush_i.
- IDLE: on start, load A=multiplicand_i, B=multiplier_i, P=0, cnt=0, go RUN. Otherwise stay.
- RUN, per cycle:
  - if B[0], P = P + A (mod 2^DATA_WIDTH);
  - A = A<<1; B = B>>1; cnt = cnt+1;
  - go DONE when the updated B==0 or updated cnt==DATA_WIDTH;
  - always at least one RUN cycle.
- DONE: done_o=1, go IDLE unconditionally. A MUL still present on the inputs in this cycle does not restart.
- flush_i in IDLE blocks start. In RUN: go IDLE next cycle, no done_o, P left partial. In DONE: ignored.
- stall_o = start | (state==RUN), combinational. It is low in DONE, so the pipeline advances exactly once with the result.
- result_o = P, registered. It holds its value until the next start clears it.
- Product is unsigned shift-add; the low DATA_WIDTH bits equal the signed MUL result, so no sign handling is needed.
- Non-MUL operations pass untouched: stall_o=0, done_o=0.

## Timing
- Reset (async, reset==0): state=IDLE, A=B=P=0, cnt=0, stall_o=0, done_o=0, result_o=0.
- Reset mid-RUN aborts immediately, with no done_o after release.
- Let n = max(1, bit index of highest 1 in multiplier_i + 1). Stall cycles = 1 (start) + n (RUN). done_o occurs in cycle n+1 after the start cycle.
- Worst case: multiplier MSB set, n=DATA_WIDTH, stall = DATA_WIDTH+1 cycles.
- Back-to-back MULs: the second MUL enters EX the cycle after DONE and starts that cycle. No idle gap beyond the DONE cycle.
- Operands are sampled only in the start cycle; changes during RUN are ignored.
- Simultaneous flush_i and MUL in IDLE: no start, stall_o=0.
- Simultaneous flush_i with the final RUN iteration: flush wins, state goes IDLE, no done_o.

## Test plan
- Reset check: hold reset=0 with MUL valid and operands 7,9 → stall_o=0, done_o=0, result_o=0 throughout. Release reset → start next cycle.
- Basic product: MUL 7×9 (multiplier 4'b1001, n=4) → stall_o high 5 cycles, done_o on the 6th, result_o=63.
- Corner operands:
  - multiplier 0 → n=1, 2 stall cycles, result 0;
  - 0xFFFFFFFF×0xFFFFFFFF → 33 stall cycles, result 0x00000001;
  - −3×5 (0xFFFFFFFD×5) → result 0xFFFFFFF1.
- Back-to-back: MUL 6×7 then MUL 3×0x80000000 → results 42 then 0x80000000, the second start occurring the cycle after the first DONE.
- Flush: assert flush_i during the 3rd RUN cycle of 5×0xFF → IDLE next cycle, stall_o drops, no done_o. A following ADD (op 4'b0000) sees stall_o=0.
- Non-MUL / bubble: ALU_Operation_i=4'b0001 valid, and MUL with valid_i=0 → stall_o=0, done_o=0, result_o unchanged from the previous product.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// EX-stage multiply sequencer bundle: ALU-side request/operands in, stall/result out.
interface mul_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]            ALU_Operation_i;
  logic                  valid_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] multiplicand_i;
  logic [DATA_WIDTH-1:0] multiplier_i;
  logic                  stall_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output ALU_Operation_i, valid_i, flush_i, multiplicand_i, multiplier_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  ALU_Operation_i, valid_i, flush_i, multiplicand_i, multiplier_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiply controller for EX: stalls the pipeline while it
// runs, then releases it for one cycle with the low DATA_WIDTH product bits.
module mul_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  MUL_OP     = 4'b1110
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  start;

  // Gated by reset so the combinational stall stays low while reset is held.
  assign start = reset && (state_q == IDLE) && bus.valid_i &&
                 (bus.ALU_Operation_i == MUL_OP) && !bus.flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = bus.multiplicand_i;
          b_d     = bus.multiplier_i;
          p_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          if (b_q[0]) p_d = p_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
          // Exit as soon as no multiplier bits remain; skips leading zeros.
          if ((b_d == '0) || (cnt_d == CNT_MAX)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.stall_o  = start || (state_q == RUN);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = p_q;

endmodule
